// File: rtl/memory_game_param.sv
// memory_game_param: multi-round "watch the pairs, then repeat them" controller.
// The game flashes NUM_PAIRS LED pairs one after another, then waits for the
// player to reproduce each pair on the switches. It keeps a saturating score,
// a wrapping round counter and a miss budget that ends the game when used up.
// Every output is a register, so an input event shows up one cycle later.
module memory_game_param #(
   parameter int NUM_SW       = 16,
   parameter int NUM_PAIRS    = 3,
   parameter int IDX_W        = 4,
   parameter int FLASH_CYCLES = 50000000,
   parameter int MAX_MISSES   = 3,
   parameter int SCORE_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         start,
   input  logic                         submit,
   input  logic [NUM_PAIRS*2*IDX_W-1:0] pair_idx,
   input  logic [NUM_SW-1:0]            switch_in,
   input  logic                         game_timeout,
   output logic [NUM_SW-1:0]            flash_leds,
   output logic [NUM_PAIRS-1:0]         pair_done,
   output logic                         red_light,
   output logic [SCORE_W-1:0]           score,
   output logic [3:0]                   round,
   output logic [3:0]                   misses,
   output logic                         busy,
   output logic                         end_game
);

   localparam int PW = NUM_PAIRS * 2 * IDX_W;
   localparam int KW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam int TW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FLASH = 2'd1;
   localparam logic [1:0] S_GUESS = 2'd2;
   localparam logic [1:0] S_END   = 2'd3;

   localparam logic [KW-1:0]      K_LAST     = KW'(NUM_PAIRS - 1);
   localparam logic [TW-1:0]      T_LAST     = TW'(FLASH_CYCLES - 1);
   localparam logic [3:0]         MISS_LIMIT = 4'(MAX_MISSES);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   logic [1:0]        state;
   logic [KW-1:0]     k;
   logic [TW-1:0]     timer;

   logic [NUM_SW-1:0]    mask_cur;
   logic [NUM_SW-1:0]    mask_nxt;
   logic [NUM_SW-1:0]    mask_first;
   logic [NUM_PAIRS-1:0] done_bit;
   logic [3:0]           misses_inc;
   logic [SCORE_W-1:0]   score_inc;

   logic in_play;
   logic do_timeout;
   logic do_start;
   logic flash_tick;
   logic flash_term;
   logic flash_wrap;
   logic guess_eval;
   logic guess_hit;
   logic guess_miss;
   logic round_end;
   logic lose;

   // One-hot LED for a single index; indices beyond the LED vector light nothing.
   function automatic logic [NUM_SW-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_SW-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         if (idx == IDX_W'(i)) m[i] = 1'b1;
      end
      return m;
   endfunction

   // LED mask of pair 'sel': OR of both one-hots, so equal indices give one bit.
   function automatic logic [NUM_SW-1:0] pair_mask(input logic [PW-1:0]  vec,
                                                   input logic [KW-1:0] sel);
      logic [NUM_SW-1:0] m;
      m = '0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
         if (sel == KW'(p)) begin
            m = onehot(vec[(2*p+1)*IDX_W +: IDX_W]) | onehot(vec[2*p*IDX_W +: IDX_W]);
         end
      end
      return m;
   endfunction

   // Masks and incremented values used by the registers below.
   always_comb begin
      mask_cur   = pair_mask(pair_idx, k);
      mask_nxt   = pair_mask(pair_idx, k + KW'(1));
      mask_first = pair_mask(pair_idx, '0);
      misses_inc = misses + 4'd1;
      score_inc  = (score == SCORE_MAX) ? score : score + SCORE_W'(1);
      done_bit   = '0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
         if (k == KW'(p)) done_bit[p] = 1'b1;
      end
   end

   // Event decode in priority order: hold when disabled, then timeout, start, submit.
   always_comb begin
      in_play    = (state == S_FLASH) || (state == S_GUESS);
      do_timeout = enable && game_timeout && in_play;
      do_start   = enable && !do_timeout && start;
      flash_tick = enable && !do_timeout && !start && (state == S_FLASH);
      flash_term = flash_tick && (timer == T_LAST);
      flash_wrap = flash_term && (k == K_LAST);
      guess_eval = enable && !do_timeout && !start && (state == S_GUESS) && submit;
      guess_hit  = guess_eval && (switch_in == mask_cur);
      guess_miss = guess_eval && (switch_in != mask_cur);
      round_end  = guess_hit && (k == K_LAST);
      lose       = guess_miss && (misses_inc == MISS_LIMIT);
   end

   // Game state: a finished round loops back to FLASH, a timeout or used-up miss budget ends it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else if (do_timeout) begin
         state <= S_END;
      end else if (do_start) begin
         state <= S_FLASH;
      end else if (flash_wrap) begin
         state <= S_GUESS;
      end else if (round_end) begin
         state <= S_FLASH;
      end else if (lose) begin
         state <= S_END;
      end
   end

   // Pair pointer: walks the pairs while flashing and again while guessing.
   always_ff @(posedge clk) begin
      if (rst) begin
         k <= '0;
      end else if (do_timeout) begin
         k <= k;
      end else if (do_start || round_end) begin
         k <= '0;
      end else if (flash_term) begin
         k <= flash_wrap ? '0 : k + KW'(1);
      end else if (guess_hit) begin
         k <= k + KW'(1);
      end
   end

   // Flash timer: counts the display cycles of the current pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
      end else if (do_timeout || do_start || round_end) begin
         timer <= '0;
      end else if (flash_tick) begin
         timer <= flash_term ? '0 : timer + TW'(1);
      end
   end

   // LED output: shows the current pair while flashing, dark everywhere else.
   always_ff @(posedge clk) begin
      if (rst) begin
         flash_leds <= '0;
      end else if (do_timeout || lose) begin
         flash_leds <= '0;
      end else if (do_start || round_end) begin
         flash_leds <= mask_first;
      end else if (flash_tick) begin
         if (flash_wrap) begin
            flash_leds <= '0;
         end else if (flash_term) begin
            flash_leds <= mask_nxt;
         end else begin
            flash_leds <= mask_cur;
         end
      end
   end

   // Per-pair matched flags; a completed round clears them for the next round.
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_done <= '0;
      end else if (do_start || round_end) begin
         pair_done <= '0;
      end else if (guess_hit) begin
         pair_done <= pair_done | done_bit;
      end
   end

   // Red light reflects the outcome of the most recent evaluated submit.
   always_ff @(posedge clk) begin
      if (rst) begin
         red_light <= 1'b0;
      end else if (do_start || guess_hit) begin
         red_light <= 1'b0;
      end else if (guess_miss) begin
         red_light <= 1'b1;
      end
   end

   // Score: one point per matched pair, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         score <= '0;
      end else if (do_start) begin
         score <= '0;
      end else if (guess_hit) begin
         score <= score_inc;
      end
   end

   // Completed-round counter, wrapping naturally at 4 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         round <= '0;
      end else if (do_start) begin
         round <= '0;
      end else if (round_end) begin
         round <= round + 4'd1;
      end
   end

   // Wrong-submit counter for the current game.
   always_ff @(posedge clk) begin
      if (rst) begin
         misses <= '0;
      end else if (do_start) begin
         misses <= '0;
      end else if (guess_miss) begin
         misses <= misses_inc;
      end
   end

   // Status flags: busy while a game is in play, end_game once it is over.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         end_game <= 1'b0;
      end else if (do_timeout || lose) begin
         busy     <= 1'b0;
         end_game <= 1'b1;
      end else if (do_start) begin
         busy     <= 1'b1;
         end_game <= 1'b0;
      end
   end

endmodule

// File: tb/tb_memory_game_param.sv
// Bench for memory_game_param: directed vector table, hand-written corner
// sequences and randomized play against a game-level reference model.
module tb_memory_game_param;

   localparam int NSW = 16;
   localparam int NP  = 3;
   localparam int FC  = 4;
   localparam int MM  = 2;
   localparam bit N   = 1'b0;
   localparam bit Y   = 1'b1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, enable, start, submit, game_timeout;
   logic [23:0]   pair_idx;
   logic [29:0]   pair_idx5;
   logic [15:0]   switch_in;

   logic [15:0]   flash_leds;
   logic [2:0]    pair_done;
   logic          red_light;
   logic [7:0]    score;
   logic [3:0]    round;
   logic [3:0]    misses;
   logic          busy;
   logic          end_game;

   logic [15:0]   f5_flash;
   logic [2:0]    f5_pd;
   logic          f5_red;
   logic [7:0]    f5_score;
   logic [3:0]    f5_round;
   logic [3:0]    f5_misses;
   logic          f5_busy;
   logic          f5_end;

   memory_game_param #(.NUM_SW(NSW), .NUM_PAIRS(NP), .IDX_W(4), .FLASH_CYCLES(FC),
                       .MAX_MISSES(MM), .SCORE_W(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .submit(submit),
      .pair_idx(pair_idx), .switch_in(switch_in), .game_timeout(game_timeout),
      .flash_leds(flash_leds), .pair_done(pair_done), .red_light(red_light),
      .score(score), .round(round), .misses(misses), .busy(busy), .end_game(end_game));

   memory_game_param #(.NUM_SW(NSW), .NUM_PAIRS(NP), .IDX_W(5), .FLASH_CYCLES(FC),
                       .MAX_MISSES(MM), .SCORE_W(8)) dut5 (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .submit(submit),
      .pair_idx(pair_idx5), .switch_in(switch_in), .game_timeout(game_timeout),
      .flash_leds(f5_flash), .pair_done(f5_pd), .red_light(f5_red),
      .score(f5_score), .round(f5_round), .misses(f5_misses), .busy(f5_busy), .end_game(f5_end));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (game level) ----------------
   // mode: 0 idle, 1 showing pairs, 2 player guessing, 3 game over
   int m_mode = 0, m_shown = 0, m_gk = 0;
   int e_flash = 0, e_pd = 0, e_red = 0, e_score = 0, e_round = 0, e_misses = 0, e_busy = 0, e_end = 0;

   function automatic int mmask(input logic [23:0] pv, input int p);
      int a, b, m;
      a = int'((pv >> ((2 * p + 1) * 4)) & 24'hF);
      b = int'((pv >> (2 * p * 4)) & 24'hF);
      m = 0;
      if (a < NSW) m = m | (1 << a);
      if (b < NSW) m = m | (1 << b);
      return m;
   endfunction

   task automatic new_game();
      m_mode = 1; m_shown = 0; m_gk = 0;
      e_flash = mmask(pair_idx, 0);
      e_pd = 0; e_red = 0; e_score = 0; e_round = 0; e_misses = 0; e_busy = 1; e_end = 0;
   endtask

   task automatic game_over();
      m_mode = 3; e_end = 1; e_busy = 0; e_flash = 0;
   endtask

   // Applies the inputs that the coming clock edge will sample.
   task automatic model_step();
      if (rst) begin
         m_mode = 0; m_shown = 0; m_gk = 0;
         e_flash = 0; e_pd = 0; e_red = 0; e_score = 0; e_round = 0; e_misses = 0; e_busy = 0; e_end = 0;
      end else if (enable) begin
         if (game_timeout && (m_mode == 1 || m_mode == 2)) begin
            game_over();
         end else if (start) begin
            new_game();
         end else if (m_mode == 1) begin
            m_shown++;
            if (m_shown == NP * FC) begin
               m_mode = 2; m_gk = 0; e_flash = 0;
            end else begin
               e_flash = mmask(pair_idx, m_shown / FC);
            end
         end else if (m_mode == 2 && submit) begin
            if (int'(switch_in) == mmask(pair_idx, m_gk)) begin
               e_pd = e_pd | (1 << m_gk);
               e_red = 0;
               if (e_score < 255) e_score++;
               if (m_gk == NP - 1) begin
                  e_round = (e_round + 1) % 16;
                  e_pd = 0; m_gk = 0; m_mode = 1; m_shown = 0;
                  e_flash = mmask(pair_idx, 0);
               end else begin
                  m_gk++;
               end
            end else begin
               e_red = 1;
               e_misses++;
               if (e_misses == MM) game_over();
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      cyc++;
      check($sformatf("c%0d_flash", cyc),  32'(flash_leds), 32'(e_flash));
      check($sformatf("c%0d_pdone", cyc),  32'(pair_done),  32'(e_pd));
      check($sformatf("c%0d_red", cyc),    32'(red_light),  32'(e_red));
      check($sformatf("c%0d_score", cyc),  32'(score),      32'(e_score));
      check($sformatf("c%0d_round", cyc),  32'(round),      32'(e_round));
      check($sformatf("c%0d_misses", cyc), 32'(misses),     32'(e_misses));
      check($sformatf("c%0d_busy", cyc),   32'(busy),       32'(e_busy));
      check($sformatf("c%0d_end", cyc),    32'(end_game),   32'(e_end));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_flash"},  32'(flash_leds), 32'd0);
      check({tag, "_pdone"},  32'(pair_done),  32'd0);
      check({tag, "_red"},    32'(red_light),  32'd0);
      check({tag, "_score"},  32'(score),      32'd0);
      check({tag, "_round"},  32'(round),      32'd0);
      check({tag, "_misses"}, 32'(misses),     32'd0);
      check({tag, "_busy"},   32'(busy),       32'd0);
      check({tag, "_end"},    32'(end_game),   32'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          st, sb, to;
      logic [15:0] sw;
      logic [15:0] fl;
      logic [2:0]  pd;
      bit          red;
      logic [7:0]  sc;
      logic [3:0]  rd, ms;
      bit          bsy, eg;
      bit          c5;
      logic [15:0] fl5;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input bit st, input bit sb, input logic [15:0] sw, input bit to,
                       input logic [15:0] fl, input logic [2:0] pd, input bit red,
                       input logic [7:0] sc, input logic [3:0] rd, input logic [3:0] ms,
                       input bit bsy, input bit eg);
      vec_t v;
      v.st = st; v.sb = sb; v.sw = sw; v.to = to;
      v.fl = fl; v.pd = pd; v.red = red; v.sc = sc; v.rd = rd; v.ms = ms;
      v.bsy = bsy; v.eg = eg; v.c5 = 1'b0; v.fl5 = 16'h0;
      tbl.push_back(v);
   endtask

   task automatic idle(input int n, input logic [15:0] fl, input logic [7:0] sc,
                       input logic [3:0] rd, input logic [3:0] ms);
      for (int i = 0; i < n; i++) addv(N, N, 16'h0, N, fl, 3'b000, N, sc, rd, ms, Y, N);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, want summary before time limit");
      $fatal(1);
   end

   initial begin
      int n24;
      rst = 1'b1; enable = 1'b1; start = 1'b0; submit = 1'b0; game_timeout = 1'b0;
      switch_in = 16'h0;
      pair_idx  = 24'h435261;                                   // (1,6) (2,5) (3,4)
      pair_idx5 = {5'd4, 5'd3, 5'd20, 5'd12, 5'd7, 5'd7};      // (7,7) (12,20) (3,4)

      // game 1: three flashes, three hits, new round
      addv(Y, N, 16'h0, N, 16'h42, 3'b000, N, 8'd0, 4'd0, 4'd0, Y, N);
      idle(3, 16'h42, 8'd0, 4'd0, 4'd0);
      idle(4, 16'h24, 8'd0, 4'd0, 4'd0);
      idle(4, 16'h18, 8'd0, 4'd0, 4'd0);
      idle(1, 16'h00, 8'd0, 4'd0, 4'd0);
      addv(N, Y, 16'h42, N, 16'h0,  3'b001, N, 8'd1, 4'd0, 4'd0, Y, N);
      addv(N, Y, 16'h24, N, 16'h0,  3'b011, N, 8'd2, 4'd0, 4'd0, Y, N);
      addv(N, Y, 16'h18, N, 16'h42, 3'b000, N, 8'd3, 4'd1, 4'd0, Y, N);
      idle(3, 16'h42, 8'd3, 4'd1, 4'd0);
      idle(4, 16'h24, 8'd3, 4'd1, 4'd0);
      idle(4, 16'h18, 8'd3, 4'd1, 4'd0);
      idle(1, 16'h00, 8'd3, 4'd1, 4'd0);
      // misses and loss
      addv(N, Y, 16'h41, N, 16'h0, 3'b000, Y, 8'd3, 4'd1, 4'd1, Y, N);
      addv(N, Y, 16'h42, N, 16'h0, 3'b001, N, 8'd4, 4'd1, 4'd1, Y, N);
      addv(N, Y, 16'h00, N, 16'h0, 3'b001, Y, 8'd4, 4'd1, 4'd2, N, Y);
      addv(N, Y, 16'h24, N, 16'h0, 3'b001, Y, 8'd4, 4'd1, 4'd2, N, Y);
      addv(N, N, 16'h00, Y, 16'h0, 3'b001, Y, 8'd4, 4'd1, 4'd2, N, Y);
      // restart from END, then timeout racing a correct submit
      addv(Y, N, 16'h0, N, 16'h42, 3'b000, N, 8'd0, 4'd0, 4'd0, Y, N);
      idle(3, 16'h42, 8'd0, 4'd0, 4'd0);
      idle(4, 16'h24, 8'd0, 4'd0, 4'd0);
      idle(4, 16'h18, 8'd0, 4'd0, 4'd0);
      idle(1, 16'h00, 8'd0, 4'd0, 4'd0);
      addv(N, Y, 16'h42, Y, 16'h0,  3'b000, N, 8'd0, 4'd0, 4'd0, N, Y);
      addv(Y, N, 16'h0,  N, 16'h42, 3'b000, N, 8'd0, 4'd0, 4'd0, Y, N);
      // timeout during FLASH, restart, restart again mid-flash
      addv(N, N, 16'h0, Y, 16'h0,  3'b000, N, 8'd0, 4'd0, 4'd0, N, Y);
      addv(Y, N, 16'h0, N, 16'h42, 3'b000, N, 8'd0, 4'd0, 4'd0, Y, N);
      idle(2, 16'h42, 8'd0, 4'd0, 4'd0);
      addv(Y, N, 16'h0, N, 16'h42, 3'b000, N, 8'd0, 4'd0, 4'd0, Y, N);
      idle(3, 16'h42, 8'd0, 4'd0, 4'd0);
      idle(1, 16'h24, 8'd0, 4'd0, 4'd0);

      // second instance (IDX_W=5) during the first flash sequence
      for (int i = 0; i <= 12; i++) begin
         tbl[i].c5  = 1'b1;
         tbl[i].fl5 = (i < 4) ? 16'h0080 : (i < 8) ? 16'h1000 : (i < 12) ? 16'h0018 : 16'h0000;
      end

      // reset
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         start = tbl[i].st; submit = tbl[i].sb; switch_in = tbl[i].sw; game_timeout = tbl[i].to;
         tick();
         check($sformatf("v%0d_flash", i),  32'(flash_leds), 32'(tbl[i].fl));
         check($sformatf("v%0d_pdone", i),  32'(pair_done),  32'(tbl[i].pd));
         check($sformatf("v%0d_red", i),    32'(red_light),  32'(tbl[i].red));
         check($sformatf("v%0d_score", i),  32'(score),      32'(tbl[i].sc));
         check($sformatf("v%0d_round", i),  32'(round),      32'(tbl[i].rd));
         check($sformatf("v%0d_misses", i), 32'(misses),     32'(tbl[i].ms));
         check($sformatf("v%0d_busy", i),   32'(busy),       32'(tbl[i].bsy));
         check($sformatf("v%0d_end", i),    32'(end_game),   32'(tbl[i].eg));
         if (tbl[i].c5) check($sformatf("v%0d_flash_idx5", i), 32'(f5_flash), 32'(tbl[i].fl5));
      end
      start = 1'b0; submit = 1'b0; game_timeout = 1'b0; switch_in = 16'h0;

      // freeze with enable low in the middle of pair 1
      tick();
      for (int i = 0; i < 10; i++) begin
         enable = 1'b0;
         start = 1'($urandom_range(0, 1)); submit = 1'($urandom_range(0, 1));
         game_timeout = 1'($urandom_range(0, 1));
         tick();
         check("freeze_flash", 32'(flash_leds), 32'h24);
         check("freeze_busy",  32'(busy),       32'd1);
      end
      enable = 1'b1; start = 1'b0; submit = 1'b0; game_timeout = 1'b0;
      n24 = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (flash_leds == 16'h24) n24++;
         else break;
      end
      check("freeze_remaining_cycles", 32'(n24), 32'd2);
      check("freeze_next_pair", 32'(flash_leds), 32'h18);

      // reach GUESS, score once, then reset mid-game together with start
      for (int c = 0; c < 20 && !(busy === 1'b1 && flash_leds === 16'h0); c++) tick();
      check("reach_guess", 32'(busy === 1'b1 && flash_leds === 16'h0), 32'd1);
      submit = 1'b1; switch_in = 16'h42;
      tick();
      check("pre_reset_score", 32'(score), 32'd1);
      submit = 1'b0; rst = 1'b1; start = 1'b1;
      tick();
      check_zero("rst_mid_guess");
      rst = 1'b0; start = 1'b0;
      tick();

      // sixteen perfect rounds: round counter wraps 15 -> 0
      start = 1'b1;
      tick();
      start = 1'b0; submit = 1'b1;
      for (int c = 1; c <= 240; c++) begin
         switch_in = 16'(mmask(pair_idx, m_gk));
         tick();
         if (c == 225) begin
            check("wrap_round15", 32'(round), 32'd15);
            check("wrap_score45", 32'(score), 32'd45);
         end
      end
      check("wrap_round0", 32'(round), 32'd0);
      check("wrap_score48", 32'(score), 32'd48);
      submit = 1'b0;

      // randomized play
      for (int c = 0; c < 4000; c++) begin
         rst          = ($urandom_range(0, 499) == 0);
         enable       = ($urandom_range(0, 9) != 0);
         start        = ($urandom_range(0, 199) == 0) ||
                        ((m_mode == 0 || m_mode == 3) && $urandom_range(0, 7) == 0);
         if (start) pair_idx = 24'($urandom);
         game_timeout = ($urandom_range(0, 249) == 0);
         submit       = ($urandom_range(0, 2) == 0);
         switch_in    = ($urandom_range(0, 9) != 0) ? 16'(mmask(pair_idx, m_gk)) : 16'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
